uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 46 ++++
 rtl/uart_tx_fifo.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if -- signal bundle between a byte producer, the UART TX FIFO
// and the downstream transmitter.
//
// Handshake semantics:
//   write side : wr_en/wr_data is a one-byte-per-cycle strobe with no ready.
//                A strobe while full=1 is dropped and answered by a one-cycle
//                overflow pulse on the next cycle.
//   transmit   : tx_start is a one-cycle pulse with tx_data valid from that
//                cycle on. tx_data stays stable until the transmitter answers
//                with a one-cycle tx_done pulse. Only one byte is ever
//                outstanding, and tx_done outside that window is ignored.
//
// Signals:
//   wr_en, wr_data  producer -> FIFO
//   tx_done         transmitter -> FIFO
//   tx_start, tx_data       FIFO -> transmitter
//   full, empty, count      FIFO occupancy (count = stored, not-yet-issued bytes)
//   overflow, busy          status pulses / level
//   dbg_state               FSM state for debug and checker binding
interface uart_tx_fifo_if #(
  parameter int AW = 4
) ();
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          tx_done;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          busy;
  logic [1:0]    dbg_state;

  // Producer / transmitter side.
  modport master (
    output wr_en, wr_data, tx_done,
    input  tx_start, tx_data, full, empty, count, overflow, busy, dbg_state
  );

  // FIFO side.
  modport slave (
    input  wr_en, wr_data, tx_done,
    output tx_start, tx_data, full, empty, count, overflow, busy, dbg_state
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- byte FIFO feeding a UART transmitter one byte at a time.
//
// A circular buffer of DEPTH bytes accepts one write per cycle. A three-state
// FSM (IDLE -> SEND -> WAIT_DONE) pops the oldest byte, presents it on a
// registered tx_data with a one-cycle tx_start pulse, and waits for tx_done
// before issuing the next byte.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    uart_tx_fifo_if.slave (write strobe, transmitter handshake, status)
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]  mem [DEPTH];

  state_t      state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        overflow_q, overflow_d;

  logic        full_w;
  logic        empty_w;
  logic        wr_acc;
  logic        pop;

  // Full is judged on the registered count only, so a pop in the same cycle
  // never rescues a write attempted while full.
  assign full_w  = (count_q == FULL_CNT);
  assign empty_w = (count_q == '0);
  assign wr_acc  = bus.wr_en && !full_w;

  // FSM next-state and transmit register logic.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_w) begin
          pop        = 1'b1;
          tx_data_d  = mem[rd_ptr_q];
          tx_start_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pointer, occupancy and overflow next-state logic.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = bus.wr_en && full_w;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; stale bytes are unreachable once the pointers and
  // count are cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;

endmodule
